// File: rtl/ox_pkg.sv
// Shared types and constants for the O/X referee.
// Holds the state enum, result/reject codes and the 8 winning lines.
package ox_pkg;

  typedef enum logic [1:0] {
    IDLE,
    WAIT_MOVE,
    EVAL,
    DONE
  } state_t;

  localparam logic [1:0] W_NONE = 2'd0;
  localparam logic [1:0] W_O    = 2'd1;
  localparam logic [1:0] W_X    = 2'd2;
  localparam logic [1:0] W_DRAW = 2'd3;

  localparam logic [1:0] REJ_NONE  = 2'd0;
  localparam logic [1:0] REJ_TURN  = 2'd1;
  localparam logic [1:0] REJ_RANGE = 2'd2;
  localparam logic [1:0] REJ_OCC   = 2'd3;

  // Rows, columns, then both diagonals (board bit indices)
  localparam logic [3:0] LINES [8][3] = '{
    '{4'd0, 4'd1, 4'd2},
    '{4'd3, 4'd4, 4'd5},
    '{4'd6, 4'd7, 4'd8},
    '{4'd0, 4'd3, 4'd6},
    '{4'd1, 4'd4, 4'd7},
    '{4'd2, 4'd5, 4'd8},
    '{4'd0, 4'd4, 4'd8},
    '{4'd2, 4'd4, 4'd6}
  };

  function automatic logic [8:0] cell_mask(
    input logic [3:0] pos
  );
    logic [15:0] s;
    s = 16'd1 << (pos - 4'd1);
    return s[8:0];
  endfunction

endpackage

// File: rtl/ox_line_eval.sv
// Combinational line counter for the 3x3 board.
// A line counts when all three cells are taken by the same side.
module ox_line_eval
  import ox_pkg::*;
(
  input  logic [8:0] occ,
  input  logic [8:0] own,
  output logic [3:0] cnt_o,
  output logic [3:0] cnt_x
);

  always_comb begin
    cnt_o = '0;
    cnt_x = '0;
    for (int i = 0; i < 8; i++) begin
      if (occ[LINES[i][0]] &&
          occ[LINES[i][1]] &&
          occ[LINES[i][2]]) begin
        if (own[LINES[i][0]] &&
            own[LINES[i][1]] &&
            own[LINES[i][2]]) begin
          cnt_x = cnt_x + 4'd1;
        end else if (!(own[LINES[i][0]] ||
                       own[LINES[i][1]] ||
                       own[LINES[i][2]])) begin
          cnt_o = cnt_o + 4'd1;
        end
      end
    end
  end

endmodule

// File: rtl/ox_game_ctrl.sv
// Turn-order and legality referee for a 3x3 O/X game.
// Build with OX_TIMEOUT_EN to add a per-move idle forfeit and timeout port.
module ox_game_ctrl
  import ox_pkg::*;
#(
  parameter logic FIRST_PLAYER   = 1'b0,
  parameter int   TIMEOUT_CYCLES = 255
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic       in_player,
  input  logic [3:0] in_pos,
  output logic       move_ack,
  output logic       move_rej,
  output logic [1:0] rej_code,
  output logic       turn,
  output logic [8:0] occ,
  output logic [8:0] own,
  output logic [3:0] line_o,
  output logic [3:0] line_x,
  output logic       game_over,
  output logic [1:0] winner,
  output logic [3:0] move_cnt
`ifdef OX_TIMEOUT_EN
  ,
  output logic       timeout
`endif
);

  if (TIMEOUT_CYCLES < 1) begin : g_cfg_chk
    $error("TIMEOUT_CYCLES must be at least 1");
  end

  state_t     state;
  logic       hs;
  logic [8:0] mask;
  logic [1:0] chk;
  logic [3:0] cnt_o;
  logic [3:0] cnt_x;
  logic [3:0] mover_cnt;

  ox_line_eval u_eval (
    .occ   (occ),
    .own   (own),
    .cnt_o (cnt_o),
    .cnt_x (cnt_x)
  );

  assign hs        = in_valid & in_ready;
  assign mask      = cell_mask(in_pos);
  assign mover_cnt = turn ? cnt_x : cnt_o;

  always_comb begin
    chk = REJ_NONE;
    if (in_player != turn) begin
      chk = REJ_TURN;
    end else if (in_pos == 4'd0 || in_pos > 4'd9) begin
      chk = REJ_RANGE;
    end else if ((occ & mask) != 9'd0) begin
      chk = REJ_OCC;
    end
  end

`ifdef OX_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TW-1:0] IDLE_LAST = TW'(TIMEOUT_CYCLES - 1);
  logic [TW-1:0] idle;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      in_ready  <= 1'b0;
      move_ack  <= 1'b0;
      move_rej  <= 1'b0;
      rej_code  <= REJ_NONE;
      turn      <= FIRST_PLAYER;
      occ       <= '0;
      own       <= '0;
      line_o    <= '0;
      line_x    <= '0;
      game_over <= 1'b0;
      winner    <= W_NONE;
      move_cnt  <= '0;
`ifdef OX_TIMEOUT_EN
      idle      <= '0;
      timeout   <= 1'b0;
`endif
    end else begin
      move_ack <= 1'b0;
      move_rej <= 1'b0;
      rej_code <= REJ_NONE;
      if (start) begin
        // A same-cycle move is dropped: the new game wins
        state     <= WAIT_MOVE;
        in_ready  <= 1'b1;
        turn      <= FIRST_PLAYER;
        occ       <= '0;
        own       <= '0;
        line_o    <= '0;
        line_x    <= '0;
        game_over <= 1'b0;
        winner    <= W_NONE;
        move_cnt  <= '0;
`ifdef OX_TIMEOUT_EN
        idle      <= '0;
        timeout   <= 1'b0;
`endif
      end else begin
        unique case (state)
          IDLE: begin
          end
          WAIT_MOVE: begin
            if (hs) begin
`ifdef OX_TIMEOUT_EN
              idle <= '0;
`endif
              if (chk != REJ_NONE) begin
                move_rej <= 1'b1;
                rej_code <= chk;
              end else begin
                occ      <= occ | mask;
                own      <= own | (turn ? mask : 9'd0);
                move_cnt <= move_cnt + 4'd1;
                move_ack <= 1'b1;
                in_ready <= 1'b0;
                state    <= EVAL;
              end
            end
`ifdef OX_TIMEOUT_EN
            else if (idle == IDLE_LAST) begin
              state     <= DONE;
              in_ready  <= 1'b0;
              game_over <= 1'b1;
              timeout   <= 1'b1;
              winner    <= turn ? W_O : W_X;
            end else begin
              idle <= idle + 1'b1;
            end
`endif
          end
          EVAL: begin
            line_o <= cnt_o;
            line_x <= cnt_x;
            if (mover_cnt != 4'd0) begin
              state     <= DONE;
              game_over <= 1'b1;
              winner    <= turn ? W_X : W_O;
            end else if (move_cnt == 4'd9) begin
              state     <= DONE;
              game_over <= 1'b1;
              winner    <= W_DRAW;
            end else begin
              state    <= WAIT_MOVE;
              in_ready <= 1'b1;
              turn     <= ~turn;
`ifdef OX_TIMEOUT_EN
              idle     <= '0;
`endif
            end
          end
          DONE: begin
          end
          default: begin
            state <= IDLE;
          end
        endcase
      end
    end
  end

endmodule
